// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: display fetch takes each pixel-change slot, writer/reader round-robin on the rest.
// Latency: RAM command 1 cycle after decision, read data 3 cycles after; requesters are stalled via ready on tick cycles.
module vga_fb_arbiter #(
    parameter int FB_W     = 160,
    parameter int FB_H     = 120,
    parameter int SCALE_SH = 2,
    parameter int AW       = 15,
    parameter int DW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [8:0]    vga_row,
    input  logic [9:0]    vga_col,
    input  logic          vga_display,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_valid,
    output logic          rd_ready,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_data_valid,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] pixel_data,
    output logic          pixel_valid
);
    localparam logic [31:0] FB_SIZE = 32'(FB_W * FB_H);

    logic [8:0]    r_row_q;
    logic [9:0]    r_col_q;
    logic          r_seen_q;
    logic          r_last_rd;
    logic [AW-1:0] r_mem_addr;
    logic          r_mem_we;
    logic [DW-1:0] r_mem_wdata;
    logic          r_s1_vld, r_s1_disp, r_s1_oor;
    logic          r_s2_vld, r_s2_disp, r_s2_oor;
    logic [DW-1:0] r_pix;
    logic          r_pix_vld;
    logic [DW-1:0] r_rd_data;
    logic          r_rd_vld;

    logic          w_tick;
    logic          w_free;
    logic          w_gnt_rd;
    logic          w_wr_xfer;
    logic          w_rd_xfer;
    logic          w_wr_oor;
    logic          w_rd_oor;
    logic [AW-1:0] w_disp_addr;

    assign w_tick      = vga_display && (!r_seen_q || vga_col != r_col_q || vga_row != r_row_q);
    assign w_free      = !w_tick;
    // Reader wins when alone or on a tie it did not win last; an idle bus parks the grant on the writer.
    assign w_gnt_rd    = rd_valid && (!wr_valid || !r_last_rd);
    assign wr_ready    = !rst && w_free && !w_gnt_rd;
    assign rd_ready    = !rst && w_free && w_gnt_rd;
    assign w_wr_xfer   = wr_valid && wr_ready;
    assign w_rd_xfer   = rd_valid && rd_ready;
    assign w_wr_oor    = 32'(wr_addr) >= FB_SIZE;
    assign w_rd_oor    = 32'(rd_addr) >= FB_SIZE;
    assign w_disp_addr = AW'(32'(vga_row >> SCALE_SH) * 32'(FB_W) + 32'(vga_col >> SCALE_SH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row_q     <= '0;
            r_col_q     <= '0;
            r_seen_q    <= 1'b0;
            r_last_rd   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_s1_vld    <= 1'b0;
            r_s1_disp   <= 1'b0;
            r_s1_oor    <= 1'b0;
            r_s2_vld    <= 1'b0;
            r_s2_disp   <= 1'b0;
            r_s2_oor    <= 1'b0;
            r_pix       <= '0;
            r_pix_vld   <= 1'b0;
            r_rd_data   <= '0;
            r_rd_vld    <= 1'b0;
        end else begin
            r_row_q   <= vga_row;
            r_col_q   <= vga_col;
            r_seen_q  <= 1'b1;
            r_mem_we  <= 1'b0;
            r_s1_vld  <= 1'b0;
            r_s1_disp <= 1'b0;
            r_s1_oor  <= 1'b0;
            if (w_tick) begin
                r_mem_addr <= w_disp_addr;
                r_s1_vld   <= 1'b1;
                r_s1_disp  <= 1'b1;
            end else if (w_wr_xfer) begin
                r_last_rd <= 1'b0;
                if (!w_wr_oor) begin
                    r_mem_addr  <= wr_addr;
                    r_mem_we    <= 1'b1;
                    r_mem_wdata <= wr_data;
                end
            end else if (w_rd_xfer) begin
                // Out-of-range reads still travel the pipe so the response pulse keeps its slot.
                r_last_rd <= 1'b1;
                r_s1_vld  <= 1'b1;
                r_s1_oor  <= w_rd_oor;
                if (!w_rd_oor) begin
                    r_mem_addr <= rd_addr;
                end
            end

            r_s2_vld  <= r_s1_vld;
            r_s2_disp <= r_s1_disp;
            r_s2_oor  <= r_s1_oor;

            r_pix_vld <= 1'b0;
            r_rd_vld  <= 1'b0;
            if (r_s2_vld && r_s2_disp) begin
                r_pix     <= mem_rdata;
                r_pix_vld <= 1'b1;
            end else if (!vga_display) begin
                r_pix <= '0;
            end
            if (r_s2_vld && !r_s2_disp) begin
                r_rd_data <= r_s2_oor ? '0 : mem_rdata;
                r_rd_vld  <= 1'b1;
            end
        end
    end

    assign mem_addr      = r_mem_addr;
    assign mem_we        = r_mem_we;
    assign mem_wdata     = r_mem_wdata;
    assign pixel_data    = r_pix;
    assign pixel_valid   = r_pix_vld;
    assign rd_data       = r_rd_data;
    assign rd_data_valid = r_rd_vld;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a synchronous RAM model preloaded with addr[7:0]^8'h5A.
module tb_vga_fb_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [8:0]  vga_row = '0;
    logic [9:0]  vga_col = '0;
    logic        vga_display = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [14:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        rd_valid = 1'b0;
    logic        rd_ready;
    logic [14:0] rd_addr = '0;
    logic [7:0]  rd_data;
    logic        rd_data_valid;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic [7:0]  pixel_data;
    logic        pixel_valid;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] ram [0:32767];
    bit         written [0:32767];

    vga_fb_arbiter dut (
        .clk(clk), .rst(rst),
        .vga_row(vga_row), .vga_col(vga_col), .vga_display(vga_display),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .pixel_data(pixel_data), .pixel_valid(pixel_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr]     <= mem_wdata;
            written[mem_addr] <= 1'b1;
        end
        mem_rdata <= written[mem_addr] ? ram[mem_addr] : (mem_addr[7:0] ^ 8'h5A);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".mem_addr"},   32'(mem_addr), 32'd0);
        chk({tag, ".mem_we"},     32'(mem_we), 32'd0);
        chk({tag, ".mem_wdata"},  32'(mem_wdata), 32'd0);
        chk({tag, ".rd_data"},    32'(rd_data), 32'd0);
        chk({tag, ".rd_dvld"},    32'(rd_data_valid), 32'd0);
        chk({tag, ".pixel_data"}, 32'(pixel_data), 32'd0);
        chk({tag, ".pixel_vld"},  32'(pixel_valid), 32'd0);
        chk({tag, ".wr_ready"},   32'(wr_ready), 32'd0);
        chk({tag, ".rd_ready"},   32'(rd_ready), 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) nxt();
        #2;
        chk_all_zero("reset");

        // Pixel (0,0) fetched on the first cycle after reset
        nxt();
        rst = 1'b0;
        vga_display = 1'b1;
        #2;
        chk("t1.c0.wr_ready", 32'(wr_ready), 32'd0);
        nxt(); #2;
        chk("t1.c1.wr_ready", 32'(wr_ready), 32'd1);
        chk("t1.c1.mem_addr", 32'(mem_addr), 32'd0);
        chk("t1.c1.pix_vld", 32'(pixel_valid), 32'd0);
        nxt(); #2;
        chk("t1.c2.pix_vld", 32'(pixel_valid), 32'd0);
        nxt(); #2;
        chk("t1.c3.pix_vld", 32'(pixel_valid), 32'd1);
        chk("t1.c3.pix_dat", 32'(pixel_data), 32'h5A);
        nxt(); #2;
        chk("t1.c4.pix_vld", 32'(pixel_valid), 32'd0);
        chk("t1.c4.pix_dat", 32'(pixel_data), 32'h5A);

        // Active line, col advancing every 2 cycles, both requesters always valid
        for (int j = 1; j <= 7; j++) begin
            nxt();
            vga_col  = 10'(j);
            wr_valid = 1'b1; wr_addr = 15'd300; wr_data = 8'h11;
            rd_valid = 1'b1; rd_addr = 15'd200;
            #2;
            chk("t2.tick.wr_ready", 32'(wr_ready), 32'd0);
            chk("t2.tick.rd_ready", 32'(rd_ready), 32'd0);
            chk("t2.tick.mem_we", 32'(mem_we), 32'((j >= 3) && (j % 2 == 1)));
            chk("t2.tick.rd_dvld", 32'(rd_data_valid), 32'((j >= 3) && (j % 2 == 1)));
            if ((j >= 3) && (j % 2 == 1)) begin
                chk("t2.tick.wr_addr", 32'(mem_addr), 32'd300);
                chk("t2.tick.rd_data", 32'(rd_data), 32'h92);
            end
            chk("t2.tick.pix_vld", 32'(pixel_valid), 32'd0);
            nxt(); #2;
            chk("t2.free.mem_addr", 32'(mem_addr), 32'(j >> 2));
            chk("t2.free.mem_we", 32'(mem_we), 32'd0);
            chk("t2.free.rd_ready", 32'(rd_ready), 32'(j % 2 == 1));
            chk("t2.free.wr_ready", 32'(wr_ready), 32'(j % 2 == 0));
            chk("t2.free.pix_vld", 32'(pixel_valid), 32'(j >= 2));
            if (j >= 2) chk("t2.free.pix_dat", 32'(pixel_data), 32'((j - 1) >> 2) ^ 32'h5A);
        end
        nxt();
        wr_valid = 1'b0; rd_valid = 1'b0; vga_display = 1'b0;
        nxt(); #2;
        chk("t2.last.pix_vld", 32'(pixel_valid), 32'd1);
        chk("t2.last.pix_dat", 32'(pixel_data), 32'h5B);
        nxt(); #2;
        chk("t2.last.rd_dvld", 32'(rd_data_valid), 32'd1);
        chk("t2.blank.pix_dat", 32'(pixel_data), 32'd0);

        // Blanking: writer streams addr 5..9 back to back
        for (int k = 0; k < 5; k++) begin
            nxt();
            wr_valid = 1'b1; wr_addr = 15'(5 + k); wr_data = 8'(8'hB0 + k);
            #2;
            chk("t3.wr_ready", 32'(wr_ready), 32'd1);
            if (k >= 1) begin
                chk("t3.mem_we", 32'(mem_we), 32'd1);
                chk("t3.mem_addr", 32'(mem_addr), 32'(4 + k));
            end
        end
        nxt();
        wr_valid = 1'b0;
        #2;
        chk("t3.last.mem_we", 32'(mem_we), 32'd1);
        chk("t3.last.mem_addr", 32'(mem_addr), 32'd9);
        chk("t3.last.mem_wdata", 32'(mem_wdata), 32'hB4);
        nxt();
        rd_valid = 1'b1; rd_addr = 15'd7;
        #2;
        chk("t3.idle.mem_we", 32'(mem_we), 32'd0);
        chk("t3.rd_ready", 32'(rd_ready), 32'd1);
        nxt();
        rd_valid = 1'b0;
        #2;
        chk("t3.h1.mem_addr", 32'(mem_addr), 32'd7);
        chk("t3.h1.rd_dvld", 32'(rd_data_valid), 32'd0);
        nxt(); #2;
        chk("t3.h2.rd_dvld", 32'(rd_data_valid), 32'd0);
        nxt(); #2;
        chk("t3.h3.rd_dvld", 32'(rd_data_valid), 32'd1);
        chk("t3.h3.rd_data", 32'(rd_data), 32'hB2);

        // Out-of-range write dropped, out-of-range read returns zero
        nxt();
        wr_valid = 1'b1; wr_addr = 15'd19200; wr_data = 8'hEE;
        #2;
        chk("t4.oorw.wr_ready", 32'(wr_ready), 32'd1);
        nxt();
        wr_valid = 1'b0;
        rd_valid = 1'b1; rd_addr = 15'd19200;
        #2;
        chk("t4.oorw.mem_we", 32'(mem_we), 32'd0);
        chk("t4.oorw.mem_addr", 32'(mem_addr), 32'd7);
        chk("t4.oorr.rd_ready", 32'(rd_ready), 32'd1);
        nxt();
        rd_valid = 1'b0;
        #2;
        chk("t4.oorr.h1.rd_dvld", 32'(rd_data_valid), 32'd0);
        nxt(); nxt(); #2;
        chk("t4.oorr.h3.rd_dvld", 32'(rd_data_valid), 32'd1);
        chk("t4.oorr.h3.rd_data", 32'(rd_data), 32'd0);

        // Address mapping at the bottom-right pixel, then a line wrap
        nxt();
        vga_display = 1'b1; vga_row = 9'd479; vga_col = 10'd639;
        #2;
        chk("t5.br.wr_ready", 32'(wr_ready), 32'd0);
        nxt(); #2;
        chk("t5.br.mem_addr", 32'(mem_addr), 32'd19199);
        nxt(); nxt(); #2;
        chk("t5.br.pix_vld", 32'(pixel_valid), 32'd1);
        chk("t5.br.pix_dat", 32'(pixel_data), 32'hA5);
        nxt();
        vga_display = 1'b0; vga_row = 9'd10; vga_col = 10'd799;
        #2;
        chk("t5.blank.wr_ready", 32'(wr_ready), 32'd1);
        nxt();
        vga_display = 1'b1; vga_row = 9'd11; vga_col = 10'd0;
        #2;
        chk("t5.blank.pix_dat", 32'(pixel_data), 32'd0);
        chk("t5.wrap.wr_ready", 32'(wr_ready), 32'd0);
        nxt();
        vga_display = 1'b0;
        #2;
        chk("t5.wrap.mem_addr", 32'(mem_addr), 32'd320);
        repeat (4) nxt();

        // Reset one cycle after a read handshake kills the read
        rd_valid = 1'b1; rd_addr = 15'd200;
        #2;
        chk("t6.rd_ready", 32'(rd_ready), 32'd1);
        nxt();
        rd_valid = 1'b0; rst = 1'b1;
        #2;
        chk_all_zero("t6.inrst");
        nxt(); #2;
        chk("t6.inrst2.rd_dvld", 32'(rd_data_valid), 32'd0);
        nxt();
        rst = 1'b0;
        vga_display = 1'b1; vga_row = 9'd20; vga_col = 10'd40;
        #2;
        chk("t6.r0.wr_ready", 32'(wr_ready), 32'd0);
        chk("t6.r0.rd_dvld", 32'(rd_data_valid), 32'd0);
        nxt(); #2;
        chk("t6.r1.mem_addr", 32'(mem_addr), 32'd810);
        chk("t6.r1.rd_dvld", 32'(rd_data_valid), 32'd0);
        nxt(); #2;
        chk("t6.r2.rd_dvld", 32'(rd_data_valid), 32'd0);
        nxt(); #2;
        chk("t6.r3.rd_dvld", 32'(rd_data_valid), 32'd0);
        chk("t6.r3.pix_vld", 32'(pixel_valid), 32'd1);
        chk("t6.r3.pix_dat", 32'(pixel_data), 32'h70);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
